// File: rtl/lane_judge_scorer.sv
// Rhythm-game judgement engine: grades lane presses inside a per-beat timing
// window and keeps a saturating score, current combo and max combo for display.
module lane_judge_scorer #(
    parameter int unsigned NUM_LANES      = 4,
    parameter int unsigned SCORE_BITS     = 14,
    parameter int unsigned COMBO_BITS     = 14,
    parameter int unsigned SCORE_MAX      = 9999,
    parameter int unsigned WINDOW_CYCLES  = 12500000,
    parameter int unsigned PERFECT_CYCLES = 2500000,
    parameter int unsigned PERFECT_PTS    = 3,
    parameter int unsigned GOOD_PTS       = 1,
    parameter int unsigned MULT_COMBO     = 8,
    parameter int unsigned COMBO_SHOW     = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  run,
    input  logic                  clear,
    input  logic                  beat_tick,
    input  logic [NUM_LANES-1:0]  arrow_pattern,
    input  logic [NUM_LANES-1:0]  btn,
    output logic                  judge_valid,
    output logic [1:0]            judge_code,
    output logic [NUM_LANES-1:0]  lane_hit,
    output logic                  wrong_press,
    output logic [SCORE_BITS-1:0] score,
    output logic [COMBO_BITS-1:0] combo,
    output logic [COMBO_BITS-1:0] max_combo,
    output logic                  combo_en
);

    localparam int unsigned CNT_BITS = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam logic [CNT_BITS-1:0]   WIN_LAST   = CNT_BITS'(WINDOW_CYCLES - 1);
    localparam logic [SCORE_BITS+1:0] PT_PERFECT = (SCORE_BITS+2)'(PERFECT_PTS);
    localparam logic [SCORE_BITS+1:0] PT_GOOD    = (SCORE_BITS+2)'(GOOD_PTS);
    localparam logic [SCORE_BITS+1:0] SCORE_CAP  = (SCORE_BITS+2)'(SCORE_MAX);
    localparam logic [SCORE_BITS-1:0] SCORE_SAT  = SCORE_BITS'(SCORE_MAX);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WINDOW  = 2'd1;
    localparam logic [1:0] ST_RESOLVE = 2'd2;

    localparam logic [1:0] CODE_MISS    = 2'b01;
    localparam logic [1:0] CODE_GOOD    = 2'b10;
    localparam logic [1:0] CODE_PERFECT = 2'b11;

    logic [1:0]            state_r;
    logic [NUM_LANES-1:0]  pattern_r;
    logic [NUM_LANES-1:0]  hit_r;
    logic [NUM_LANES-1:0]  pendPat_r;
    logic [NUM_LANES-1:0]  btnPrev_r;
    logic                  wrong_r;
    logic                  pendVld_r;
    logic [CNT_BITS-1:0]   winCnt_r;
    logic [CNT_BITS-1:0]   lastHit_r;
    logic [SCORE_BITS-1:0] score_r;
    logic [COMBO_BITS-1:0] combo_r;
    logic [COMBO_BITS-1:0] maxCombo_r;
    logic                  comboEn_r;
    logic [1:0]            codeHeld_r;

    logic                  active_s;
    logic [NUM_LANES-1:0]  press_s;
    logic [NUM_LANES-1:0]  laneHit_s;
    logic [NUM_LANES-1:0]  newHit_s;
    logic                  wrongPress_s;
    logic                  judgeValid_s;
    logic                  goResolve_s;
    logic [1:0]            grade_s;
    logic [SCORE_BITS+1:0] ptsBase_s;
    logic [SCORE_BITS+1:0] pts_s;
    logic [SCORE_BITS+1:0] sum_s;
    logic [SCORE_BITS-1:0] scoreNext_s;
    logic [COMBO_BITS-1:0] comboNext_s;
    logic                  nextPendVld_s;
    logic [NUM_LANES-1:0]  nextPendPat_s;

    // A lane left unhit or any stray press spoils the beat; otherwise timing of the last hit decides.
    function automatic logic [1:0] gradeBeat(
        input logic [NUM_LANES-1:0] pat,
        input logic [NUM_LANES-1:0] hit,
        input logic                 wrong,
        input logic [CNT_BITS-1:0]  idx
    );
        logic [1:0] code;
        if (wrong || (hit != pat)) begin
            code = CODE_MISS;
        end else if (32'(idx) < PERFECT_CYCLES) begin
            code = CODE_PERFECT;
        end else begin
            code = CODE_GOOD;
        end
        return code;
    endfunction

    assign active_s = reset_n & run & ~clear;
    assign press_s  = btn & ~btnPrev_r;
    assign grade_s  = gradeBeat(pattern_r, hit_r, wrong_r, lastHit_r);

    // Per-cycle press classification and window-exit decision.
    always_comb begin
        laneHit_s    = '0;
        wrongPress_s = 1'b0;
        judgeValid_s = 1'b0;
        goResolve_s  = 1'b0;
        newHit_s     = hit_r;
        if (active_s) begin
            case (state_r)
                ST_IDLE: begin
                    wrongPress_s = |press_s;
                end
                ST_WINDOW: begin
                    laneHit_s    = press_s & pattern_r & ~hit_r;
                    wrongPress_s = |(press_s & ~(pattern_r & ~hit_r));
                    newHit_s     = hit_r | laneHit_s;
                    goResolve_s  = (newHit_s == pattern_r) || (winCnt_r == WIN_LAST) || beat_tick;
                end
                ST_RESOLVE: begin
                    judgeValid_s = 1'b1;
                end
                default: begin
                    judgeValid_s = 1'b0;
                end
            endcase
        end else begin
            judgeValid_s = 1'b0;
        end
    end

    // Points, saturating score and combo that the RESOLVE cycle would commit.
    always_comb begin
        ptsBase_s = '0;
        case (grade_s)
            CODE_PERFECT: ptsBase_s = PT_PERFECT;
            CODE_GOOD:    ptsBase_s = PT_GOOD;
            default:      ptsBase_s = '0;
        endcase
        if (32'(combo_r) >= MULT_COMBO) begin
            pts_s = {ptsBase_s[SCORE_BITS:0], 1'b0};
        end else begin
            pts_s = ptsBase_s;
        end
        sum_s = {2'b00, score_r} + pts_s;
        if (sum_s > SCORE_CAP) begin
            scoreNext_s = SCORE_SAT;
        end else begin
            scoreNext_s = sum_s[SCORE_BITS-1:0];
        end
        if (grade_s == CODE_MISS) begin
            comboNext_s = '0;
        end else if (combo_r == '1) begin
            comboNext_s = combo_r;
        end else begin
            comboNext_s = combo_r + COMBO_BITS'(1);
        end
    end

    // A beat landing in the RESOLVE cycle itself chains straight into the next window.
    always_comb begin
        if (beat_tick) begin
            nextPendVld_s = 1'b1;
            nextPendPat_s = arrow_pattern;
        end else begin
            nextPendVld_s = pendVld_r;
            nextPendPat_s = pendPat_r;
        end
    end

    // Edge detector history; tracks btn even while paused so held buttons never count on resume.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btnPrev_r <= '0;
        end else begin
            btnPrev_r <= btn;
        end
    end

    // Judgement FSM, window counter and pending-beat store.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            pattern_r <= '0;
            hit_r     <= '0;
            wrong_r   <= 1'b0;
            winCnt_r  <= '0;
            lastHit_r <= '0;
            pendPat_r <= '0;
            pendVld_r <= 1'b0;
        end else if (clear) begin
            state_r   <= ST_IDLE;
            pattern_r <= '0;
            hit_r     <= '0;
            wrong_r   <= 1'b0;
            winCnt_r  <= '0;
            lastHit_r <= '0;
            pendPat_r <= '0;
            pendVld_r <= 1'b0;
        end else if (run) begin
            case (state_r)
                ST_IDLE: begin
                    if (beat_tick && (arrow_pattern != '0)) begin
                        state_r   <= ST_WINDOW;
                        pattern_r <= arrow_pattern;
                        hit_r     <= '0;
                        wrong_r   <= 1'b0;
                        winCnt_r  <= '0;
                        lastHit_r <= '0;
                    end
                end
                ST_WINDOW: begin
                    hit_r <= newHit_s;
                    if (laneHit_s != '0) begin
                        lastHit_r <= winCnt_r;
                    end
                    if (wrongPress_s) begin
                        wrong_r <= 1'b1;
                    end
                    if (beat_tick) begin
                        pendPat_r <= arrow_pattern;
                        pendVld_r <= 1'b1;
                    end
                    if (goResolve_s) begin
                        state_r <= ST_RESOLVE;
                    end else begin
                        winCnt_r <= winCnt_r + CNT_BITS'(1);
                    end
                end
                ST_RESOLVE: begin
                    pendPat_r <= '0;
                    pendVld_r <= 1'b0;
                    hit_r     <= '0;
                    wrong_r   <= 1'b0;
                    winCnt_r  <= '0;
                    lastHit_r <= '0;
                    if (nextPendVld_s && (nextPendPat_s != '0)) begin
                        state_r   <= ST_WINDOW;
                        pattern_r <= nextPendPat_s;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Score and combo bookkeeping, committed on the edge leaving RESOLVE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            score_r    <= '0;
            combo_r    <= '0;
            maxCombo_r <= '0;
            comboEn_r  <= 1'b0;
            codeHeld_r <= 2'b00;
        end else if (clear) begin
            score_r    <= '0;
            combo_r    <= '0;
            maxCombo_r <= '0;
            comboEn_r  <= 1'b0;
            codeHeld_r <= 2'b00;
        end else if (run && (state_r == ST_RESOLVE)) begin
            score_r    <= scoreNext_s;
            combo_r    <= comboNext_s;
            comboEn_r  <= (32'(comboNext_s) >= COMBO_SHOW);
            codeHeld_r <= grade_s;
            if (comboNext_s > maxCombo_r) begin
                maxCombo_r <= comboNext_s;
            end
        end
    end

    assign judge_valid = judgeValid_s;
    assign judge_code  = judgeValid_s ? grade_s : codeHeld_r;
    assign lane_hit    = laneHit_s;
    assign wrong_press = wrongPress_s;
    assign score       = score_r;
    assign combo       = combo_r;
    assign max_combo   = maxCombo_r;
    assign combo_en    = comboEn_r;

endmodule

// File: tb/tb_lane_judge_scorer.sv
// Directed bench for lane_judge_scorer with a short window; a second instance
// with a tiny score ceiling shadows the same stimulus to exercise saturation.
module tb_lane_judge_scorer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       run;
    logic       clear;
    logic       beat_tick;
    logic [3:0] arrow_pattern;
    logic [3:0] btn;

    logic        jvA, wpA, ceA, jvB, wpB, ceB;
    logic [1:0]  jcA, jcB;
    logic [3:0]  lhA, lhB;
    logic [13:0] scA, coA, mcA, scB, coB, mcB;

    int checks = 0;
    int errors = 0;
    int expA, expB, pts;

    always #5 clk = ~clk;

    lane_judge_scorer #(.WINDOW_CYCLES(16), .PERFECT_CYCLES(4)) dutA (
        .clk(clk), .reset_n(reset_n), .run(run), .clear(clear), .beat_tick(beat_tick),
        .arrow_pattern(arrow_pattern), .btn(btn), .judge_valid(jvA), .judge_code(jcA),
        .lane_hit(lhA), .wrong_press(wpA), .score(scA), .combo(coA), .max_combo(mcA), .combo_en(ceA)
    );

    lane_judge_scorer #(.WINDOW_CYCLES(16), .PERFECT_CYCLES(4), .SCORE_MAX(10)) dutB (
        .clk(clk), .reset_n(reset_n), .run(run), .clear(clear), .beat_tick(beat_tick),
        .arrow_pattern(arrow_pattern), .btn(btn), .judge_valid(jvB), .judge_code(jcB),
        .lane_hit(lhB), .wrong_press(wpB), .score(scB), .combo(coB), .max_combo(mcB), .combo_en(ceB)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock, then apply this cycle's inputs and let outputs settle.
    task automatic cyc(input logic bt, input logic [3:0] pat, input logic [3:0] b,
                       input logic r = 1'b1, input logic c = 1'b0);
        @(posedge clk);
        #1;
        beat_tick     = bt;
        arrow_pattern = pat;
        btn           = b;
        run           = r;
        clear         = c;
        #1;
    endtask

    initial begin
        reset_n = 1'b0; run = 1'b1; clear = 1'b0;
        beat_tick = 1'b0; arrow_pattern = 4'h0; btn = 4'h0;
        cyc(1'b0, 4'h0, 4'h0);
        cyc(1'b0, 4'h0, 4'h0);
        chk("rst_jv", 32'(jvA), 32'd0);   chk("rst_jc", 32'(jcA), 32'd0);
        chk("rst_lh", 32'(lhA), 32'd0);   chk("rst_wp", 32'(wpA), 32'd0);
        chk("rst_sc", 32'(scA), 32'd0);   chk("rst_co", 32'(coA), 32'd0);
        chk("rst_mc", 32'(mcA), 32'd0);   chk("rst_ce", 32'(ceA), 32'd0);
        chk("rstB_jv", 32'(jvB), 32'd0);  chk("rstB_jc", 32'(jcB), 32'd0);
        chk("rstB_lh", 32'(lhB), 32'd0);  chk("rstB_wp", 32'(wpB), 32'd0);
        chk("rstB_sc", 32'(scB), 32'd0);  chk("rstB_co", 32'(coB), 32'd0);
        chk("rstB_mc", 32'(mcB), 32'd0);  chk("rstB_ce", 32'(ceB), 32'd0);
        reset_n = 1'b1;

        // Perfect: lane0 pressed at window index 2
        cyc(1'b1, 4'b0001, 4'h0);
        chk("perf_beat_jv", 32'(jvA), 32'd0);
        cyc(1'b0, 4'h0, 4'h0);
        cyc(1'b0, 4'h0, 4'h0);
        cyc(1'b0, 4'h0, 4'b0001);
        chk("perf_lh", 32'(lhA), 32'b0001);
        chk("perf_wp", 32'(wpA), 32'd0);
        cyc(1'b0, 4'h0, 4'b0001);
        chk("perf_jv", 32'(jvA), 32'd1);
        chk("perf_jc", 32'(jcA), 32'b11);
        cyc(1'b0, 4'h0, 4'h0);
        chk("perf_jv_off", 32'(jvA), 32'd0);
        chk("perf_sc", 32'(scA), 32'd3);
        chk("perf_co", 32'(coA), 32'd1);
        chk("perf_ce", 32'(ceA), 32'd0);
        chk("perf_jc_hold", 32'(jcA), 32'b11);

        // Good: lanes 0 and 2, last hit at index 10
        cyc(1'b1, 4'b0101, 4'h0);
        cyc(1'b0, 4'h0, 4'h0);
        cyc(1'b0, 4'h0, 4'b0001);
        chk("good_lh0", 32'(lhA), 32'b0001);
        for (int i = 2; i < 10; i++) cyc(1'b0, 4'h0, 4'h0);
        cyc(1'b0, 4'h0, 4'b0100);
        chk("good_lh2", 32'(lhA), 32'b0100);
        cyc(1'b0, 4'h0, 4'h0);
        chk("good_jv", 32'(jvA), 32'd1);
        chk("good_jc", 32'(jcA), 32'b10);
        cyc(1'b0, 4'h0, 4'h0);
        chk("good_sc", 32'(scA), 32'd4);
        chk("good_co", 32'(coA), 32'd2);
        chk("good_ce", 32'(ceA), 32'd1);

        // Wrong lane then the right lane: MISS
        cyc(1'b1, 4'b0100, 4'h0);
        cyc(1'b0, 4'h0, 4'h0);
        cyc(1'b0, 4'h0, 4'b0010);
        chk("wrong_wp", 32'(wpA), 32'd1);
        chk("wrong_lh", 32'(lhA), 32'd0);
        cyc(1'b0, 4'h0, 4'h0);
        cyc(1'b0, 4'h0, 4'b0100);
        chk("wrong_lh2", 32'(lhA), 32'b0100);
        cyc(1'b0, 4'h0, 4'h0);
        chk("wrong_jc", 32'(jcA), 32'b01);
        cyc(1'b0, 4'h0, 4'h0);
        chk("wrong_co", 32'(coA), 32'd0);
        chk("wrong_mc", 32'(mcA), 32'd2);
        chk("wrong_sc", 32'(scA), 32'd4);
        chk("wrong_ce", 32'(ceA), 32'd0);
        cyc(1'b0, 4'h0, 4'b1000);
        chk("idle_wp", 32'(wpA), 32'd1);
        cyc(1'b0, 4'h0, 4'h0);
        chk("idle_sc", 32'(scA), 32'd4);

        // Timeout: judgement 17 cycles after the beat
        cyc(1'b1, 4'b0010, 4'h0);
        for (int k = 1; k <= 16; k++) cyc(1'b0, 4'h0, 4'h0);
        chk("tmo_jv16", 32'(jvA), 32'd0);
        cyc(1'b0, 4'h0, 4'h0);
        chk("tmo_jv17", 32'(jvA), 32'd1);
        chk("tmo_jc", 32'(jcA), 32'b01);
        cyc(1'b0, 4'h0, 4'h0);
        chk("tmo_co", 32'(coA), 32'd0);

        // Clear
        cyc(1'b0, 4'h0, 4'h0, 1'b1, 1'b1);
        cyc(1'b0, 4'h0, 4'h0);
        chk("clr_sc", 32'(scA), 32'd0);
        chk("clr_mc", 32'(mcA), 32'd0);
        chk("clr_jc", 32'(jcA), 32'd0);
        chk("clrB_sc", 32'(scB), 32'd0);

        // Nine perfects: multiplier from the ninth, saturation in dutB
        expA = 0; expB = 0;
        for (int i = 0; i < 9; i++) begin
            cyc(1'b1, 4'b0001, 4'h0);
            cyc(1'b0, 4'h0, 4'b0001);
            chk("mult_lh", 32'(lhA), 32'b0001);
            cyc(1'b0, 4'h0, 4'h0);
            chk("mult_jc", 32'(jcA), 32'b11);
            cyc(1'b0, 4'h0, 4'h0);
            pts  = (i >= 8) ? 6 : 3;
            expA = expA + pts;
            expB = (expB + pts > 10) ? 10 : expB + pts;
            chk("mult_scA", 32'(scA), expA);
            chk("sat_scB", 32'(scB), expB);
        end
        chk("mult_mc", 32'(mcA), 32'd9);
        chk("mult_co", 32'(coA), 32'd9);
        chk("mult_ce", 32'(ceA), 32'd1);

        // Overlapping beat at index 5 with lane1 unhit
        cyc(1'b1, 4'b0011, 4'h0);
        cyc(1'b0, 4'h0, 4'h0);
        cyc(1'b0, 4'h0, 4'h0);
        cyc(1'b0, 4'h0, 4'b0001);
        chk("ovl_lh0", 32'(lhA), 32'b0001);
        cyc(1'b0, 4'h0, 4'h0);
        cyc(1'b0, 4'h0, 4'h0);
        cyc(1'b1, 4'b1000, 4'h0);
        chk("ovl_beat_jv", 32'(jvA), 32'd0);
        cyc(1'b0, 4'h0, 4'h0);
        chk("ovl_jv", 32'(jvA), 32'd1);
        chk("ovl_jc", 32'(jcA), 32'b01);
        cyc(1'b0, 4'h0, 4'b1000);
        chk("ovl_new_lh", 32'(lhA), 32'b1000);
        chk("ovl_co", 32'(coA), 32'd0);
        chk("ovl_mc", 32'(mcA), 32'd9);
        cyc(1'b0, 4'h0, 4'h0);
        chk("ovl_new_jv", 32'(jvA), 32'd1);
        chk("ovl_new_jc", 32'(jcA), 32'b11);
        cyc(1'b0, 4'h0, 4'h0);
        chk("ovl_sc", 32'(scA), 32'd33);
        chk("ovl_co1", 32'(coA), 32'd1);
        chk("ovlB_sc", 32'(scB), 32'd10);

        // Pause for 20 cycles mid-window, lane0 pressed and held through unpause
        cyc(1'b1, 4'b0001, 4'h0);
        cyc(1'b0, 4'h0, 4'h0);
        cyc(1'b0, 4'h0, 4'h0);
        for (int i = 0; i < 20; i++) begin
            cyc((i == 5) ? 1'b1 : 1'b0, (i == 5) ? 4'b0100 : 4'h0,
                (i >= 10) ? 4'b0001 : 4'h0, 1'b0, 1'b0);
            if (i == 10) begin
                chk("pause_lh", 32'(lhA), 32'd0);
                chk("pause_jv", 32'(jvA), 32'd0);
            end
        end
        for (int k = 0; k < 15; k++) begin
            cyc(1'b0, 4'h0, 4'b0001);
            if (k == 0) chk("resume_lh", 32'(lhA), 32'd0);
            if (k == 13) chk("resume_jv_early", 32'(jvA), 32'd0);
            if (k == 14) begin
                chk("resume_jv", 32'(jvA), 32'd1);
                chk("resume_jc", 32'(jcA), 32'b01);
            end
        end
        cyc(1'b0, 4'h0, 4'b0100);
        chk("pause_idle_wp", 32'(wpA), 32'd1);
        chk("pause_idle_lh", 32'(lhA), 32'd0);
        chk("pause_co", 32'(coA), 32'd0);
        chk("pause_sc", 32'(scA), 32'd33);
        cyc(1'b0, 4'h0, 4'h0);

        // Asynchronous reset mid-window, then a fresh window
        cyc(1'b1, 4'b0001, 4'h0);
        cyc(1'b0, 4'h0, 4'h0);
        cyc(1'b0, 4'h0, 4'h0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_sc", 32'(scA), 32'd0);
        chk("arst_co", 32'(coA), 32'd0);
        chk("arst_mc", 32'(mcA), 32'd0);
        chk("arst_jc", 32'(jcA), 32'd0);
        chk("arst_jv", 32'(jvA), 32'd0);
        chk("arst_ce", 32'(ceA), 32'd0);
        cyc(1'b0, 4'h0, 4'h0);
        reset_n = 1'b1;
        cyc(1'b1, 4'b0001, 4'h0);
        cyc(1'b0, 4'h0, 4'b0001);
        chk("post_lh", 32'(lhA), 32'b0001);
        cyc(1'b0, 4'h0, 4'h0);
        chk("post_jv", 32'(jvA), 32'd1);
        chk("post_jc", 32'(jcA), 32'b11);
        cyc(1'b0, 4'h0, 4'h0);
        chk("post_sc", 32'(scA), 32'd3);
        chk("post_co", 32'(coA), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
